// File: rtl/timer_cmd_scheduler.sv
// timer_cmd_scheduler: round-robin command front end for a shared timer.
// Optional feature macro: TIMER_SCHED_ALARM_OWNER_EN (alarm ownership).
module timer_cmd_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int PULSE_CYC = 1,
  parameter int GAP_CYC   = 1,
  parameter int CAP_WAIT  = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_an_in,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  input  logic [3*NUM_REQ-1:0]    req_cmd_in,
  input  logic [32*NUM_REQ-1:0]   req_data_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  output logic                    rsp_valid_out,
  output logic [2:0]              rsp_id_out,
  output logic [31:0]             rsp_data_out,
  output logic                    rsp_err_out,
  output logic                    tmr_start_out,
  output logic                    tmr_capture_out,
  output logic                    tmr_rst_capture_out,
  output logic                    tmr_alarm_en_out,
  output logic [31:0]             tmr_alarm_out,
  input  logic [31:0]             tmr_captured_in
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = 16;

  localparam logic [2:0] C_START = 3'd0;
  localparam logic [2:0] C_CAP   = 3'd1;
  localparam logic [2:0] C_CLR   = 3'd2;
  localparam logic [2:0] C_ASET  = 3'd3;
  localparam logic [2:0] C_AOFF  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_GAP, S_WAIT, S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [2:0]         id_q, id_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [31:0]        dat_q, dat_d;
  logic [NUM_REQ-1:0] rdy_q, rdy_d;
  logic               rv_q, rv_d;
  logic [2:0]         rid_q, rid_d;
  logic [31:0]        rdat_q, rdat_d;
  logic               rerr_q, rerr_d;
  logic [2:0]         line_q, line_d;
  logic               aen_q, aen_d;
  logic [31:0]        alm_q, alm_d;

  logic               arb_en;
  logic               arb_ok;
  int                 arb_idx;
  int                 idx;
  logic [2:0]         sel_line;
  logic               own_ok;

`ifdef TIMER_SCHED_ALARM_OWNER_EN
  logic               own_v_q, own_v_d;
  logic [2:0]         own_id_q, own_id_d;

  assign own_ok = !own_v_q || (own_id_q == id_q);

  always_ff @(posedge clk_in or negedge rst_an_in) begin
    if (!rst_an_in) begin
      own_v_q  <= 1'b0;
      own_id_q <= '0;
    end else begin
      own_v_q  <= own_v_d;
      own_id_q <= own_id_d;
    end
  end
`else
  assign own_ok = 1'b1;
`endif

  // Rotating search starting at the pointer
  always_comb begin
    arb_ok  = 1'b0;
    arb_idx = 0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!arb_ok && req_valid_in[idx]) begin
        arb_ok  = 1'b1;
        arb_idx = idx;
      end
    end
  end

  // {rst_capture, capture, start}
  always_comb begin
    sel_line = 3'b000;
    unique case (1'b1)
      (cmd_q == C_START): sel_line = 3'b001;
      (cmd_q == C_CAP):   sel_line = 3'b010;
      (cmd_q == C_CLR):   sel_line = 3'b100;
      default:            sel_line = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cmd_d   = cmd_q;
    dat_d   = dat_q;
    rdy_d   = '0;
    rv_d    = 1'b0;
    rid_d   = '0;
    rdat_d  = '0;
    rerr_d  = 1'b0;
    line_d  = 3'b000;
    aen_d   = aen_q;
    alm_d   = alm_q;
    arb_en  = 1'b0;
`ifdef TIMER_SCHED_ALARM_OWNER_EN
    own_v_d  = own_v_q;
    own_id_d = own_id_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rdy_q != '0) begin
          if (sel_line != 3'b000) begin
            state_d = S_PULSE;
            cnt_d   = '0;
            line_d  = sel_line;
          end else begin
            state_d = S_RESP;
            rv_d    = 1'b1;
            rid_d   = id_q;
            unique case (1'b1)
              (cmd_q == C_ASET): begin
                if (own_ok) begin
                  aen_d = 1'b1;
                  alm_d = dat_q;
`ifdef TIMER_SCHED_ALARM_OWNER_EN
                  own_v_d  = 1'b1;
                  own_id_d = id_q;
`endif
                end else begin
                  rerr_d = 1'b1;
                end
              end
              (cmd_q == C_AOFF): begin
                if (own_ok) begin
                  aen_d = 1'b0;
`ifdef TIMER_SCHED_ALARM_OWNER_EN
                  own_v_d = 1'b0;
`endif
                end else begin
                  rerr_d = 1'b1;
                end
              end
              default: rerr_d = 1'b1;
            endcase
          end
        end else begin
          arb_en = 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == CW'(PULSE_CYC - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          line_d = sel_line;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          cnt_d = '0;
          if (cmd_q == C_CAP) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            rv_d    = 1'b1;
            rid_d   = id_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(CAP_WAIT - 1)) begin
          state_d = S_RESP;
          cnt_d   = '0;
          rv_d    = 1'b1;
          rid_d   = id_q;
          rdat_d  = tmr_captured_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        arb_en  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Grant registers into the following IDLE cycle
    if (arb_en && arb_ok) begin
      rdy_d = NUM_REQ'(1) << arb_idx;
      id_d  = 3'(arb_idx);
      cmd_d = req_cmd_in[3*arb_idx +: 3];
      dat_d = req_data_in[32*arb_idx +: 32];
      ptr_d = PW'((arb_idx + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk_in or negedge rst_an_in) begin
    if (!rst_an_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      cmd_q   <= '0;
      dat_q   <= '0;
      rdy_q   <= '0;
      rv_q    <= 1'b0;
      rid_q   <= '0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
      line_q  <= 3'b000;
      aen_q   <= 1'b0;
      alm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cmd_q   <= cmd_d;
      dat_q   <= dat_d;
      rdy_q   <= rdy_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
      line_q  <= line_d;
      aen_q   <= aen_d;
      alm_q   <= alm_d;
    end
  end

  assign req_ready_out       = rdy_q;
  assign rsp_valid_out       = rv_q;
  assign rsp_id_out          = rid_q;
  assign rsp_data_out        = rdat_q;
  assign rsp_err_out         = rerr_q;
  assign tmr_start_out       = line_q[0];
  assign tmr_capture_out     = line_q[1];
  assign tmr_rst_capture_out = line_q[2];
  assign tmr_alarm_en_out    = aen_q;
  assign tmr_alarm_out       = alm_q;

endmodule

// File: tb/tb_timer_cmd_scheduler.sv
// Bench for timer_cmd_scheduler: vector table, scoreboard, corner sequences.
// Honours TIMER_SCHED_ALARM_OWNER_EN when defined for the build.
module tb_timer_cmd_scheduler;
  localparam int N = 4;
`ifdef TIMER_SCHED_ALARM_OWNER_EN
  localparam bit OWN = 1'b1;
`else
  localparam bit OWN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    vld = '0;
  logic [3*N-1:0]  cmd = '0;
  logic [32*N-1:0] dat = '0;
  logic [N-1:0]    rdy;
  logic            rsp_v, rsp_err;
  logic [2:0]      rsp_id;
  logic [31:0]     rsp_dat;
  logic            t_start, t_cap, t_rcap, t_aen;
  logic [31:0]     t_alm;
  logic [31:0]     tcap = '0;

  timer_cmd_scheduler dut (
    .clk_in(clk), .rst_an_in(rst_n),
    .req_valid_in(vld), .req_cmd_in(cmd), .req_data_in(dat),
    .req_ready_out(rdy),
    .rsp_valid_out(rsp_v), .rsp_id_out(rsp_id),
    .rsp_data_out(rsp_dat), .rsp_err_out(rsp_err),
    .tmr_start_out(t_start), .tmr_capture_out(t_cap),
    .tmr_rst_capture_out(t_rcap),
    .tmr_alarm_en_out(t_aen), .tmr_alarm_out(t_alm),
    .tmr_captured_in(tcap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  id;
    logic        err;
    logic [31:0] data;
    int          lat;
  } exp_t;

  typedef struct {
    int          id;
    logic [2:0]  c;
    logic [31:0] d;
    logic [31:0] cap;
    logic [2:0]  lines;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic        aen;
    logic [31:0] alm;
  } vec_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   gcyc[8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic [2:0] c,
                         input logic [31:0] d);
    cmd[3*id +: 3]  = c;
    dat[32*id +: 32] = d;
    vld[id] = 1'b1;
  endtask

  task automatic wait_grant(output int id, output int gc);
    id = -1;
    gc = 0;
    for (int t = 0; t < 50 && id < 0; t++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (rdy[i] && id < 0) id = i;
    end
    if (id < 0) begin
      errors++;
      $display("FAIL grant_timeout: got none expected a grant");
      vld = '0;
    end else begin
      gc = cyc;
      chk("grant_onehot", 64'(rdy), 64'(1) << id);
      vld[id] = 1'b0;
    end
  endtask

  task automatic drain;
    for (int t = 0; t < 50 && exp_q.size() > 0; t++) tick();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL rsp_timeout: got %0d pending expected 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (rst_n) begin
      for (int i = 0; i < N; i++)
        if (rdy[i]) gcyc[i] = cyc;
      checks++;
      if ($countones({t_start, t_cap, t_rcap}) > 1) begin
        errors++;
        $display("FAIL line_onehot: got %b expected at most one",
                 {t_rcap, t_cap, t_start});
      end
      if (rsp_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id %0d expected none",
                   rsp_id);
        end else begin
          e = exp_q.pop_front();
          if (rsp_id !== e.id || rsp_err !== e.err ||
              rsp_dat !== e.data || (cyc - gcyc[e.id]) != e.lat) begin
            errors++;
            $display("FAIL rsp: got id%0d err%0b d%h lat%0d expected id%0d err%0b d%h lat%0d",
                     rsp_id, rsp_err, rsp_dat, cyc - gcyc[e.id],
                     e.id, e.err, e.data, e.lat);
          end
        end
      end
    end
  end

  vec_t tbl[10];

  initial begin
    int g, gc, pc;
    tbl[0] = '{2, 3'd0, 32'h0,   32'h0,        3'b001, 3, 1'b0, 32'h0,
               1'b0, 32'h0};
    tbl[1] = '{1, 3'd1, 32'h0,   32'h1234,     3'b010, 6, 1'b0, 32'h1234,
               1'b0, 32'h0};
    tbl[2] = '{3, 3'd2, 32'h0,   32'h0,        3'b100, 3, 1'b0, 32'h0,
               1'b0, 32'h0};
    tbl[3] = '{0, 3'd3, 32'h100, 32'h0,        3'b000, 1, 1'b0, 32'h0,
               1'b1, 32'h100};
    tbl[4] = '{3, 3'd4, 32'h0,   32'h0,        3'b000, 1, OWN,  32'h0,
               OWN,  32'h100};
    tbl[5] = '{1, 3'd7, 32'h0,   32'h0,        3'b000, 1, 1'b1, 32'h0,
               OWN,  32'h100};
    tbl[6] = '{0, 3'd1, 32'h0,   32'hDEADBEEF, 3'b010, 6, 1'b0, 32'hDEADBEEF,
               OWN,  32'h100};
    tbl[7] = '{2, 3'd3, 32'h55,  32'h0,        3'b000, 1, OWN,  32'h0,
               1'b1, OWN ? 32'h100 : 32'h55};
    tbl[8] = '{0, 3'd4, 32'h0,   32'h0,        3'b000, 1, 1'b0, 32'h0,
               1'b0, OWN ? 32'h100 : 32'h55};
    tbl[9] = '{2, 3'd5, 32'h0,   32'h0,        3'b000, 1, 1'b1, 32'h0,
               1'b0, OWN ? 32'h100 : 32'h55};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_ctrl", {rdy, rsp_v, rsp_id, rsp_err, t_start, t_cap,
                       t_rcap, t_aen}, 64'h0);
    chk("reset_data", {rsp_dat, t_alm}, 64'h0);

    foreach (tbl[v]) begin
      tcap = tbl[v].cap;
      set_req(tbl[v].id, tbl[v].c, tbl[v].d);
      exp_q.push_back('{3'(tbl[v].id), tbl[v].err, tbl[v].rdata,
                        tbl[v].lat});
      wait_grant(g, gc);
      chk($sformatf("v%0d_grant", v), 64'(g), 64'(tbl[v].id));
      tick();
      chk($sformatf("v%0d_lines", v), {t_rcap, t_cap, t_start},
          tbl[v].lines);
      chk($sformatf("v%0d_alarm", v), {t_aen, t_alm},
          {tbl[v].aen, tbl[v].alm});
      tick();
      chk($sformatf("v%0d_lines_low", v), {t_rcap, t_cap, t_start}, 0);
      drain();
    end

    // Arm the alarm, then lose a capture to reset during its wait
    set_req(1, 3'd3, 32'hA5);
    exp_q.push_back('{3'd1, 1'b0, 32'h0, 1});
    wait_grant(g, gc);
    drain();
    tcap = 32'hCAFE;
    set_req(2, 3'd1, 32'h0);
    exp_q.push_back('{3'd2, 1'b0, 32'hCAFE, 6});
    wait_grant(g, gc);
    chk("rst_seq_grant", 64'(g), 64'd2);
    set_req(3, 3'd0, 32'h0);
    repeat (3) tick();
    chk("pre_rst_alarm", {t_aen, t_alm}, {1'b1, 32'hA5});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {rdy, rsp_v, rsp_err, t_start, t_cap, t_rcap,
                         t_aen, t_alm}, 64'h0);
    exp_q.delete();
    repeat (4) tick();
    set_req(2, 3'd0, 32'h0);
    rst_n = 1'b1;
    exp_q.push_back('{3'd2, 1'b0, 32'h0, 3});
    exp_q.push_back('{3'd3, 1'b0, 32'h0, 3});
    wait_grant(g, gc);
    chk("post_rst_first", 64'(g), 64'd2);
    wait_grant(g, gc);
    chk("post_rst_second", 64'(g), 64'd3);
    drain();

    // All four at once: order 0..3, four cycles apart
    for (int i = 0; i < N; i++) begin
      set_req(i, 3'd0, 32'h0);
      exp_q.push_back('{3'(i), 1'b0, 32'h0, 3});
    end
    pc = 0;
    for (int k = 0; k < N; k++) begin
      wait_grant(g, gc);
      chk($sformatf("rr_order%0d", k), 64'(g), 64'(k));
      if (k > 0) chk($sformatf("rr_spacing%0d", k), 64'(gc - pc), 64'd4);
      pc = gc;
    end
    drain();

    // Ownership must not survive reset
    set_req(3, 3'd3, 32'h7);
    exp_q.push_back('{3'd3, 1'b0, 32'h0, 1});
    wait_grant(g, gc);
    tick();
    chk("post_rst_aset", {t_aen, t_alm}, {1'b1, 32'h7});
    drain();

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_cmd_scheduler.md
# timer_cmd_scheduler

Shares one `timer` instance among `NUM_REQ` software or hardware requesters. Each requester issues commands (start, capture, clear-capture, alarm set/off) through a valid/ready handshake. A round-robin arbiter grants one command at a time. A sequencing FSM converts each command into correctly shaped level pulses on the timer's edge-detected inputs, or into alarm register updates, then returns a one-cycle response carrying the captured count for capture commands. It sits directly in front of `timer` and drives all of its control inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `PULSE_CYC`, 1: cycles a timer control line is held high, ≥1.
- `GAP_CYC`, 1: low cycles after a pulse before the next step, ≥1, so the rising-edge detector re-arms.
- `CAP_WAIT`, 3: cycles waited after the gap before sampling `tmr_captured_in`, ≥1.
- `clk_in` in 1: single clock.
- `rst_an_in` in 1: reset, asynchronous and active-low.
- `req_valid_in` in NUM_REQ: per-requester command valid.
- `req_cmd_in` in 3*NUM_REQ: per-requester command.
  - 000 START, 001 CAPTURE, 010 CLEAR, 011 ALARM_SET, 100 ALARM_OFF.
  - Other codes are illegal.
- `req_data_in` in 32*NUM_REQ: alarm value, used by ALARM_SET only.
- `req_ready_out` out NUM_REQ: one-hot grant pulse.
- `rsp_valid_out` out 1: one-cycle completion strobe.
- `rsp_id_out` out 3: index of the completed requester.
- `rsp_data_out` out 32: captured value for CAPTURE; 0 for all other commands.
- `rsp_err_out` out 1: command rejected.
- `tmr_start_out`, `tmr_capture_out`, `tmr_rst_capture_out` out 1: timer control levels.
- `tmr_alarm_en_out` out 1, `tmr_alarm_out` out 32: alarm programming.
- `tmr_captured_in` in 32: timer captured value.

## Operation
- Reset value of every output is 0. FSM resets to IDLE; the round-robin pointer resets to 0.
- Handshake:
  - A requester holds valid, cmd and data stable until it sees its `req_ready_out` bit.
  - Acceptance happens in the cycle `req_ready_out[i]`=1, which occurs only in IDLE.
  - Exactly one command is outstanding globally.
  - A requester must not present a new command before its response.
- Arbitration:
  - Search order starts at the pointer and proceeds pointer, pointer+1, … mod NUM_REQ.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ.
- FSM states: IDLE → PULSE → GAP → WAIT (CAPTURE only) → RESP → IDLE; ALARM_SET, ALARM_OFF and illegal codes go IDLE → RESP.
  - PULSE drives the selected line high for PULSE_CYC cycles: START→`tmr_start_out`, CAPTURE→`tmr_capture_out`, CLEAR→`tmr_rst_capture_out`.
  - GAP holds all lines low for GAP_CYC cycles.
  - WAIT lasts CAP_WAIT cycles. In its last cycle, `tmr_captured_in` is registered into the response data.
  - RESP asserts `rsp_valid_out` for one cycle with `rsp_id_out` set to the granted index.
- ALARM_SET: `tmr_alarm_out`←data, `tmr_alarm_en_out`←1.
- ALARM_OFF: `tmr_alarm_en_out`←0; `tmr_alarm_out` unchanged.
- An illegal cmd produces a response with `rsp_err_out`=1 and no timer side effects.
- At most one timer control line is high in any cycle.
- Reset mid-operation: all lines drop immediately, the command is lost and no response is issued. After reset deassertion, arbitration restarts at requester 0.

## Timing
- All outputs are registered. The grant is in cycle T.
- START/CLEAR:
  - Line high T+1 .. T+PULSE_CYC.
  - Low T+PULSE_CYC+1 .. T+PULSE_CYC+GAP_CYC.
  - `rsp_valid_out` at T+PULSE_CYC+GAP_CYC+1.
- CAPTURE: `rsp_valid_out` at T+PULSE_CYC+GAP_CYC+CAP_WAIT+1. Data is `tmr_captured_in` sampled in the preceding cycle.
- ALARM_SET/OFF/illegal: alarm outputs update and `rsp_valid_out` assert at T+1.
- The next grant is possible no earlier than the response cycle + 1.
- Requests arriving while busy wait; none are dropped.

## Configuration
- `TIMER_SCHED_ALARM_OWNER_EN` defined:
  - A successful ALARM_SET records the requester as alarm owner.
  - ALARM_SET or ALARM_OFF from a non-owner while an owner exists returns `rsp_err_out`=1 with alarm outputs unchanged.
  - ALARM_OFF by the owner clears ownership.
  - Reset clears ownership.
- `TIMER_SCHED_ALARM_OWNER_EN` undefined: any requester may set or clear the alarm, and alarm commands never report an error.

## Test plan
- Defaults: req 2 issues START, grant at T → `tmr_start_out`=1 only at T+1, response at T+3 with id=2, err=0, data=0.
- Req 1 CAPTURE with `tmr_captured_in`=0x0000_1234 held → `tmr_capture_out` high at T+1, response at T+6 with data=0x0000_1234.
- All four requesters valid at once with START → grants in order 0,1,2,3 with no overlapping pulses, each grant 4 cycles after the previous one.
- Req 0 ALARM_SET with data 0x100, then req 3 ALARM_OFF → alarm 0x100/en=1 at T+1.
  - Owner macro undefined: en=0 after req 3's command.
  - Owner macro defined: req 3 gets err=1 and en stays 1.
- Illegal cmd 111 → response at T+1 with err=1 and all tmr outputs unchanged.
- Reset asserted during the CAPTURE WAIT state → outputs are 0 immediately with no response; after release, a pending req 2 is granted before req 3.
